stdout_queue: RTL



---
 rtl/stdout_queue_pkg.sv | 14 +
 rtl/stdout_queue_if.sv | 58 +++++
 rtl/stdout_queue_sync_fifo.sv | 101 ++++++++++
 rtl/stdout_queue.sv | 105 ++++++++++
 4 files changed

// File: rtl/stdout_queue_pkg.sv
// Shared constants for the stdout queue.
//
// Holds the byte width and the drain FSM state encodings. The encodings are fixed so
// that logic outside this block (for example a debug LED mux) can decode the state.
package stdout_queue_pkg;

  localparam int unsigned DataWidth = 8;

  // Drain FSM state encodings.
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StBusy  = 2'd2;

endpackage

// File: rtl/stdout_queue_if.sv
// Bus bundle between the processor stdout port, the UART transmitter and the stdout queue.
//
// Signals:
//   in_data   stdout byte from the processor, valid while in_en is high
//   in_en     stdout enable level; every rising edge carries one byte
//   tx_data   byte presented to the UART transmitter
//   tx_start  transmit request to the UART
//   tx_ready  UART idle/ready, low while a frame is being sent
//   empty     queue holds no bytes
//   full      queue holds DEPTH bytes
//   level     number of bytes stored
//   overflow  sticky flag, set when a byte is dropped
//
// Modports:
//   master  the surroundings (processor, UART, status readers)
//   slave   the stdout queue itself
interface stdout_queue_if #(
  parameter int unsigned DEPTH = 16
);
  import stdout_queue_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DataWidth-1:0] in_data;
  logic                 in_en;
  logic [DataWidth-1:0] tx_data;
  logic                 tx_start;
  logic                 tx_ready;
  logic                 empty;
  logic                 full;
  logic [AW:0]          level;
  logic                 overflow;

  modport master (
    output in_data,
    output in_en,
    output tx_ready,
    input  tx_data,
    input  tx_start,
    input  empty,
    input  full,
    input  level,
    input  overflow
  );

  modport slave (
    input  in_data,
    input  in_en,
    input  tx_ready,
    output tx_data,
    output tx_start,
    output empty,
    output full,
    output level,
    output overflow
  );

endinterface

// File: rtl/stdout_queue_sync_fifo.sv
// Synchronous byte FIFO used by the stdout queue.
//
// DEPTH x 8 storage with a single write port and a single registered read port. Tracks the
// fill level, derives full/empty from it, and keeps a sticky overflow flag for writes that
// arrive while full.
//
// Ports:
//   clk       system clock
//   reset     synchronous active-high reset (pointers, level, overflow, read register)
//   wr_en     write request; ignored (and flagged) when full
//   wr_data   byte to write
//   rd_en     read request; must only be raised when not empty
//   rd_data   registered read data, holds its value until the next read
//   empty     level == 0
//   full      level == DEPTH
//   level     number of stored bytes
//   overflow  sticky, set by a write attempted while full
module stdout_queue_sync_fifo
  import stdout_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [DataWidth-1:0]   wr_data,
  input  logic                   rd_en,
  output logic [DataWidth-1:0]   rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [AW-1:0] PtrOne    = AW'(1);
  localparam logic [AW:0]   LevelOne  = (AW + 1)'(1);
  localparam logic [AW:0]   LevelFull = (AW + 1)'(DEPTH);

  logic [DataWidth-1:0] mem [DEPTH];

  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [AW:0]          level_q;
  logic [AW:0]          level_d;
  logic                 overflow_q;
  logic [DataWidth-1:0] rd_data_q;

  logic wr_ok;
  logic rd_ok;

  assign empty    = (level_q == '0);
  assign full     = (level_q == LevelFull);
  assign level    = level_q;
  assign overflow = overflow_q;
  assign rd_data  = rd_data_q;

  // Full is judged on the current level, so a read in the same cycle does not make room.
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  always_comb begin
    level_d = level_q;
    if (wr_ok && !rd_ok) begin
      level_d = level_q + LevelOne;
    end else if (!wr_ok && rd_ok) begin
      level_d = level_q - LevelOne;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (rd_ok) begin
        rd_ptr_q  <= rd_ptr_q + PtrOne;
        rd_data_q <= mem[rd_ptr_q];
      end
      level_q <= level_d;
      if (wr_en && full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage is not reset; stale bytes are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/stdout_queue.sv
// Byte queue between the processor stdout port and the UART transmitter.
//
// Captures one byte per rising edge of in_en, buffers up to DEPTH bytes and drains them in
// order through the UART start/ready handshake. The processor is never stalled; bytes that
// arrive while the queue is full are dropped and the sticky overflow flag is set.
//
// Ports:
//   clk    system clock, all logic on posedge
//   reset  synchronous active-high reset
//   bus    stdout_queue_if slave modport: in_data/in_en from the processor, tx_data/tx_start
//          to and tx_ready from the UART, plus empty/full/level/overflow status
module stdout_queue
  import stdout_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input logic           clk,
  input logic           reset,
  stdout_queue_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic                 prev_en_q;
  logic                 push_req;
  logic                 pop;
  logic [1:0]           state_q;
  logic [1:0]           state_d;
  logic                 tx_start_q;
  logic                 tx_start_d;
  logic [DataWidth-1:0] fifo_rd_data;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [AW:0]          fifo_level;
  logic                 fifo_overflow;

  // One push per 0->1 transition of the enable level, however long it stays high.
  assign push_req = bus.in_en & ~prev_en_q;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty && bus.tx_ready) begin
          pop     = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        // tx_ready falling means the UART has taken the byte.
        if (!bus.tx_ready) begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (bus.tx_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // tx_start is registered from the next state so it is high exactly while in StStart.
  assign tx_start_d = (state_d == StStart);

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_en_q  <= 1'b0;
      state_q    <= StIdle;
      tx_start_q <= 1'b0;
    end else begin
      prev_en_q  <= bus.in_en;
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
    end
  end

  // The FIFO read register doubles as the tx_data output: loaded on the pop, held after.
  stdout_queue_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (push_req),
    .wr_data  (bus.in_data),
    .rd_en    (pop),
    .rd_data  (fifo_rd_data),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .level    (fifo_level),
    .overflow (fifo_overflow)
  );

  assign bus.tx_data  = fifo_rd_data;
  assign bus.tx_start = tx_start_q;
  assign bus.empty    = fifo_empty;
  assign bus.full     = fifo_full;
  assign bus.level    = fifo_level;
  assign bus.overflow = fifo_overflow;

endmodule
